keypad_ps2_decoder: RTL and testbench

KEYPAD_PS2_DECODER -- requirements
Module: keypad_ps2_decoder

---
 rtl/keypad_ps2_decoder.sv | 188 ++++++++++++++++++
 tb/tb_keypad_ps2_decoder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_ps2_decoder.sv
// PS/2 keyboard frame receiver and scan-code decoder for a four-key game keypad.
// Reports the last held make code, per-key held levels and one-cycle press pulses.
module keypad_ps2_decoder #(
  parameter int unsigned TIMEOUT_CYC = 2000,
  parameter logic [7:0]  KEY_LEFT    = 8'h15,
  parameter logic [7:0]  KEY_SELECT  = 8'h5A,
  parameter logic [7:0]  KEY_RIGHT   = 8'h24,
  parameter logic [7:0]  KEY_START   = 8'h29
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_char,
  output logic       o_left,
  output logic       o_select,
  output logic       o_right,
  output logic       o_start,
  output logic [3:0] o_held,
  output logic       o_frame_err
);

  // state  | meaning
  // IDLE   | waiting for a start bit (data low on a PS/2 falling edge)
  // DATA   | shifting in 8 data bits, LSB first
  // PARITY | capturing the odd-parity bit
  // STOP   | checking the stop bit, then accept or reject the byte
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  localparam int unsigned       TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic            ps2_clk_meta, ps2_clk_sync, ps2_clk_prev;
  logic            ps2_dat_meta, ps2_dat_sync;
  logic            ps2_fall;

  logic [1:0]      state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            parity_bit;
  logic [TO_W-1:0] to_cnt;

  logic            stop_fall;
  logic            frame_ok;
  logic            byte_valid;
  logic            timeout;
  logic            frame_err;

  logic            ext_flag, brk_flag;
  logic [3:0]      key_hit;
  logic [3:0]      pulse_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ps2_clk_meta <= 1'b1;
      ps2_clk_sync <= 1'b1;
      ps2_clk_prev <= 1'b1;
      ps2_dat_meta <= 1'b1;
      ps2_dat_sync <= 1'b1;
    end else begin
      ps2_clk_meta <= i_ps2_clk;
      ps2_clk_sync <= ps2_clk_meta;
      ps2_clk_prev <= ps2_clk_sync;
      ps2_dat_meta <= i_ps2_dat;
      ps2_dat_sync <= ps2_dat_meta;
    end
  end

  assign ps2_fall = ps2_clk_prev & ~ps2_clk_sync;

  // Stop-bit handling is combinational so the decode lands one cycle after the edge.
  assign stop_fall  = ps2_fall && (state == ST_STOP);
  assign frame_ok   = ps2_dat_sync && (^{shift_reg, parity_bit});
  assign byte_valid = stop_fall && frame_ok;
  assign timeout    = !ps2_fall && (state != ST_IDLE) && (to_cnt == TO_LAST);
  assign frame_err  = (stop_fall && !frame_ok) || timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'h00;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
    end else begin
      if (ps2_fall || (state == ST_IDLE) || timeout) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (timeout) begin
        state <= ST_IDLE;
      end else if (ps2_fall) begin
        case (state)
          ST_IDLE: begin
            if (!ps2_dat_sync) begin
              state   <= ST_DATA;
              bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            shift_reg <= {ps2_dat_sync, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            parity_bit <= ps2_dat_sync;
            state      <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Priority chain keeps key_hit one-hot even if two key codes were configured equal.
  always_comb begin
    key_hit = 4'b0000;
    if (shift_reg == KEY_LEFT) begin
      key_hit = 4'b0001;
    end else if (shift_reg == KEY_SELECT) begin
      key_hit = 4'b0010;
    end else if (shift_reg == KEY_RIGHT) begin
      key_hit = 4'b0100;
    end else if (shift_reg == KEY_START) begin
      key_hit = 4'b1000;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      o_char      <= 8'h00;
      o_held      <= 4'b0000;
      pulse_q     <= 4'b0000;
      o_frame_err <= 1'b0;
    end else begin
      pulse_q     <= 4'b0000;
      o_frame_err <= frame_err;
      if (frame_err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_valid) begin
        if (shift_reg == CODE_EXT) begin
          ext_flag <= 1'b1;
        end else if (shift_reg == CODE_BRK) begin
          brk_flag <= 1'b1;
        end else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
          if (!ext_flag) begin
            if (brk_flag) begin
              o_held <= o_held & ~key_hit;
              if (shift_reg == o_char) begin
                o_char <= 8'h00;
              end
            end else begin
              o_char <= shift_reg;
              // Typematic repeats of an already-held key must not re-pulse.
              if ((key_hit != 4'b0000) && ((o_held & key_hit) == 4'b0000)) begin
                o_held  <= o_held | key_hit;
                pulse_q <= key_hit;
              end
            end
          end
        end
      end
    end
  end

  assign o_left   = pulse_q[0];
  assign o_select = pulse_q[1];
  assign o_right  = pulse_q[2];
  assign o_start  = pulse_q[3];

endmodule

// File: tb/tb_keypad_ps2_decoder.sv
// Bench for keypad_ps2_decoder: frame-level reference model with a per-cycle output
// compare, directed key scenarios and randomized scan-code traffic.
module tb_keypad_ps2_decoder;
  localparam int T = 2000;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] o_char;
  logic       o_left, o_select, o_right, o_start;
  logic [3:0] o_held;
  logic       o_frame_err;

  keypad_ps2_decoder #(.TIMEOUT_CYC(T)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_dat  (ps2_dat),
    .o_char     (o_char),
    .o_left     (o_left),
    .o_select   (o_select),
    .o_right    (o_right),
    .o_start    (o_start),
    .o_held     (o_held),
    .o_frame_err(o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0] ch;
    logic [3:0] held;
    logic [3:0] pulse;
    logic       err;
  } exp_t;

  // Reference model state: what the keypad should report, at frame granularity.
  logic [7:0] m_char;
  logic [3:0] m_held;
  logic [3:0] m_pulse;
  logic       m_err;
  bit         m_ext, m_brk, m_in_frame;
  int         since_fall;
  logic       bits_q[$];
  logic [7:0] keys[4];
  exp_t       pipe[3];

  int n_cmp = 0;
  int n_bad = 0;
  int n_print = 0;
  int pc[5];
  int base[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_cycle();
    exp_t got;
    got = '{o_char, o_held, {o_start, o_right, o_select, o_left}, o_frame_err};
    n_cmp++;
    if (got !== pipe[2]) begin
      n_bad++;
      if (n_print < 30) begin
        n_print++;
        $display("FAIL cycle @%0t: char %h held %b pulse %b err %b expected char %h held %b pulse %b err %b",
                 $time, got.ch, got.held, got.pulse, got.err,
                 pipe[2].ch, pipe[2].held, pipe[2].pulse, pipe[2].err);
      end
    end
    for (int i = 0; i < 4; i++) pc[i] += int'(got.pulse[i]);
    pc[4] += int'(got.err);
  endtask

  task automatic model_error();
    m_err = 1'b1;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int idx;
    idx = -1;
    for (int i = 3; i >= 0; i--) if (keys[i] == b) idx = i;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (!m_ext) begin
        if (m_brk) begin
          if (idx >= 0) m_held[idx] = 1'b0;
          if (b == m_char) m_char = 8'h00;
        end else begin
          m_char = b;
          if (idx >= 0 && !m_held[idx]) begin
            m_held[idx]  = 1'b1;
            m_pulse[idx] = 1'b1;
          end
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_fall(input logic d);
    logic [7:0] b;
    since_fall = 0;
    if (!m_in_frame) begin
      if (d == 1'b0) begin
        m_in_frame = 1'b1;
        bits_q.delete();
      end
    end else begin
      bits_q.push_back(d);
      if (bits_q.size() == 10) begin
        m_in_frame = 1'b0;
        for (int i = 0; i < 8; i++) b[i] = bits_q[i];
        if (bits_q[9] && ($countones({b, bits_q[8]}) % 2 == 1)) model_byte(b);
        else model_error();
      end
    end
  endtask

  // One system cycle: compare at the falling edge, then advance the output pipeline
  // that models the synchronizer + register latency between a PS/2 edge and outputs.
  task automatic cyc();
    @(negedge i_clk);
    cmp_cycle();
    @(posedge i_clk);
    #2;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = '{m_char, m_held, m_pulse, m_err};
    m_pulse = 4'b0000;
    m_err   = 1'b0;
    if (m_in_frame) begin
      since_fall++;
      if (since_fall == T) begin
        m_in_frame = 1'b0;
        model_error();
      end
    end
  endtask

  task automatic send_bit(input logic d);
    ps2_dat = d;
    repeat ($urandom_range(2, 5)) cyc();
    ps2_clk = 1'b0;
    model_fall(d);
    repeat ($urandom_range(2, 5)) cyc();
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i]);
    ps2_dat = 1'b1;
    repeat ($urandom_range(2, 6)) cyc();
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    m_char = 8'h00; m_held = 4'b0000; m_pulse = 4'b0000; m_err = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0; m_in_frame = 1'b0; since_fall = 0;
    bits_q.delete();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    repeat (3) cyc();
    i_rst_n = 1'b1;
    repeat (2) cyc();
  endtask

  task automatic settle();
    repeat (6) cyc();
  endtask

  task automatic snap();
    for (int i = 0; i < 5; i++) base[i] = pc[i];
  endtask

  function automatic int delta(input int i);
    return pc[i] - base[i];
  endfunction

  initial begin
    logic [7:0] b;
    int r;
    keys[0] = 8'h15; keys[1] = 8'h5A; keys[2] = 8'h24; keys[3] = 8'h29;
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    for (int i = 0; i < 5; i++) begin pc[i] = 0; base[i] = 0; end
    m_char = 8'h00; m_held = 4'b0000; m_pulse = 4'b0000; m_err = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0; m_in_frame = 1'b0; since_fall = 0;

    // Reset state
    i_rst_n = 1'b0;
    repeat (2) cyc();
    chk("rst_char", o_char, 8'h00);
    chk("rst_held", o_held, 4'b0000);
    chk("rst_pulses", {o_start, o_right, o_select, o_left}, 4'b0000);
    chk("rst_err", o_frame_err, 1'b0);
    do_reset();

    // Single select press
    snap();
    send(8'h5A);
    settle();
    chk("sel_pulses", delta(1), 1);
    chk("sel_held", o_held, 4'b0010);
    chk("sel_char", o_char, 8'h5A);
    chk("sel_model_held", m_held, 4'b0010);
    chk("sel_err", delta(4), 0);

    // Typematic right then release
    do_reset();
    snap();
    repeat (3) send(8'h24);
    settle();
    chk("typ_held_mid", o_held, 4'b0100);
    send(8'hF0);
    send(8'h24);
    settle();
    chk("typ_right_pulses", delta(2), 1);
    chk("typ_held", o_held, 4'b0000);
    chk("typ_char", o_char, 8'h00);

    // Left, start, release left
    do_reset();
    snap();
    send(8'h15);
    send(8'h29);
    send(8'hF0);
    send(8'h15);
    settle();
    chk("multi_left", delta(0), 1);
    chk("multi_start", delta(3), 1);
    chk("multi_held", o_held, 4'b1000);
    chk("multi_char", o_char, 8'h29);

    // Bad parity left frame while start is held
    snap();
    send_frame(8'h15, 1'b1, 1'b0, 11);
    settle();
    chk("par_err", delta(4), 1);
    chk("par_left", delta(0), 0);
    chk("par_held", o_held, 4'b1000);

    // Bad stop bit
    snap();
    send_frame(8'h5A, 1'b0, 1'b1, 11);
    settle();
    chk("stop_err", delta(4), 1);
    chk("stop_sel", delta(1), 0);

    // Truncated frame then timeout, then normal start key
    do_reset();
    snap();
    send_frame(8'h29, 1'b0, 1'b0, 5);
    repeat (T - 20) cyc();
    chk("to_early", delta(4), 0);
    repeat (40) cyc();
    chk("to_err", delta(4), 1);
    send(8'h29);
    settle();
    chk("to_start", delta(3), 1);
    chk("to_held", o_held, 4'b1000);

    // Extended codes are ignored
    do_reset();
    snap();
    send(8'hE0); send(8'h5A);
    send(8'hE0); send(8'hF0); send(8'h5A);
    settle();
    chk("ext_pulses", delta(0) + delta(1) + delta(2) + delta(3), 0);
    chk("ext_held", o_held, 4'b0000);
    chk("ext_char", o_char, 8'h00);

    // Reset mid-frame, next frame decodes
    send_frame(8'h5A, 1'b0, 1'b0, 6);
    do_reset();
    snap();
    send(8'h5A);
    settle();
    chk("midrst_sel", delta(1), 1);
    chk("midrst_held", o_held, 4'b0010);

    // Randomized scan-code traffic
    do_reset();
    for (int n = 0; n < 160; n++) begin
      case ($urandom_range(0, 11))
        0, 1, 2, 3, 9, 10: b = keys[$urandom_range(0, 3)];
        4:                 b = 8'hE0;
        5, 6:              b = 8'hF0;
        7:                 b = 8'h1C;
        default:           b = 8'($urandom_range(0, 255));
      endcase
      r = $urandom_range(0, 19);
      if (n == 80) begin
        send_frame(b, 1'b0, 1'b0, $urandom_range(2, 10));
        repeat (T + 5) cyc();
      end else begin
        send_frame(b, r == 0, r == 1, 11);
      end
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
